// File: rtl/song_pkg.sv
// Shared types and ROM word layout for the song sequencer.
package song_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ROM_WAIT,
    LOAD,
    ARM,
    PLAYING,
    END
  } state_e;

  localparam int ROM_W    = 12;
  localparam int NOTE_MSB = 11;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;

  localparam logic [DUR_MSB-DUR_LSB:0] END_MARKER_DUR = '0;

  function automatic logic [NOTE_MSB-NOTE_LSB:0] rom_note(input logic [ROM_W-1:0] w);
    return w[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [DUR_MSB-DUR_LSB:0] rom_dur(input logic [ROM_W-1:0] w);
    return w[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/song_index_counter.sv
// Song/note index registers: note advance, song advance (clears note index).
module song_index_counter #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_note_i,
  input  logic                 next_song_i,
  output logic [SONG_BITS-1:0] song_idx_o,
  output logic [NOTE_BITS-1:0] note_idx_o,
  output logic                 note_last_o
);

  logic [SONG_BITS-1:0] song_q, song_d;
  logic [NOTE_BITS-1:0] note_q, note_d;

  // Song advance wins over note advance; both wrap naturally.
  always_comb begin
    song_d = song_q;
    note_d = note_q;
    if (next_song_i) begin
      song_d = song_q + 1'b1;
      note_d = '0;
    end else if (inc_note_i) begin
      note_d = note_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      song_q <= '0;
      note_q <= '0;
    end else begin
      song_q <= song_d;
      note_q <= note_d;
    end
  end

  assign song_idx_o  = song_q;
  assign note_idx_o  = note_q;
  assign note_last_o = &note_q;

endmodule

// File: rtl/song_sequencer.sv
// Walks song ROM words and feeds them to the note player one load at a time.
module song_sequencer
  import song_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic                           next_song,
  output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
  input  logic [ROM_W-1:0]               rom_data,
  output logic [5:0]                     note_to_load,
  output logic [5:0]                     duration_to_load,
  output logic                           load_new_note,
  input  logic                           done_with_note,
  output logic                           play_enable,
  output logic                           song_done,
  output logic [SONG_BITS-1:0]           current_song
);

  state_e               state_q, state_d;
  logic [5:0]           note_q, note_d;
  logic [5:0]           dur_q, dur_d;
  logic                 inc_note, adv_song, note_last;
  logic [SONG_BITS-1:0] song_idx;
  logic [NOTE_BITS-1:0] note_idx;

  song_index_counter #(
    .SONG_BITS(SONG_BITS),
    .NOTE_BITS(NOTE_BITS)
  ) u_idx (
    .clk        (clk),
    .reset      (reset),
    .inc_note_i (inc_note),
    .next_song_i(adv_song),
    .song_idx_o (song_idx),
    .note_idx_o (note_idx),
    .note_last_o(note_last)
  );

  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    dur_d    = dur_q;
    inc_note = 1'b0;
    adv_song = 1'b0;
    case (state_q)
      IDLE:     if (play) state_d = FETCH;
      FETCH:    if (play) state_d = ROM_WAIT;
      ROM_WAIT: begin
        // ROM word is only valid this cycle, so capture it unconditionally.
        note_d  = rom_note(rom_data);
        dur_d   = rom_dur(rom_data);
        state_d = (rom_dur(rom_data) == END_MARKER_DUR) ? END : LOAD;
      end
      LOAD:     state_d = ARM;
      // Player's done flag is stale until its timer reloads; skip it here.
      ARM:      state_d = PLAYING;
      PLAYING: begin
        if (done_with_note && play) begin
          if (note_last) begin
            state_d = END;
          end else begin
            inc_note = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      END: begin
        adv_song = 1'b1;
        state_d  = FETCH;
      end
      default:  state_d = IDLE;
    endcase
    // Skip request overrides everything except IDLE.
    if (state_q != IDLE && next_song) begin
      inc_note = 1'b0;
      adv_song = 1'b1;
      state_d  = FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      note_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
    end
  end

  // Decoded straight from the state register so reset clears them at once.
  assign load_new_note    = (state_q == LOAD);
  assign song_done        = (state_q == END);
  assign play_enable      = play && (state_q != IDLE);
  assign rom_addr         = {song_idx, note_idx};
  assign current_song     = song_idx;
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench: ROM + note-player model, expected loads/song ends in a scoreboard.
module tb_song_sequencer;

  localparam int SB = 2;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play = 1'b0;
  logic          next_song = 1'b0;
  logic [SB+NB-1:0] rom_addr;
  logic [11:0]   rom_data = '0;
  logic [5:0]    note_to_load, duration_to_load;
  logic          load_new_note, done_with_note, play_enable, song_done;
  logic [SB-1:0] current_song;

  song_sequencer #(.SONG_BITS(SB), .NOTE_BITS(NB)) dut (
    .clk             (clk),
    .reset           (reset),
    .play            (play),
    .next_song       (next_song),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .note_to_load    (note_to_load),
    .duration_to_load(duration_to_load),
    .load_new_note   (load_new_note),
    .done_with_note  (done_with_note),
    .play_enable     (play_enable),
    .song_done       (song_done),
    .current_song    (current_song)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM
  logic [11:0] rom [0:127];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Note player: count down the loaded duration while enabled
  int unsigned cnt = 0;
  logic        done_force = 1'b0;
  always @(posedge clk) begin
    if (load_new_note) cnt <= int'(duration_to_load);
    else if (play_enable && cnt != 0) cnt <= cnt - 1;
  end
  assign done_with_note = done_force | (cnt == 0);

  typedef struct {
    logic       is_done;
    logic [5:0] note;
    logic [5:0] dur;
    logic [1:0] song;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_load(input int n, input int d, input int s);
    ev_t e;
    e.is_done = 1'b0;
    e.note = 6'(n);
    e.dur  = 6'(d);
    e.song = 2'(s);
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int s);
    ev_t e;
    e.is_done = 1'b1;
    e.note = '0;
    e.dur  = '0;
    e.song = 2'(s);
    exp_q.push_back(e);
  endtask

  function automatic logic [11:0] w(input int n, input int d);
    logic [31:0] nn, dd;
    nn = n;
    dd = d;
    return {nn[5:0], dd[5:0]};
  endfunction

  // Waits for a load (which=0) or song_done (which=1) within budget cycles
  task automatic wait_ev(input string name, input int which, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && load_new_note) || (which == 1 && song_done)) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: no event within %0d cycles", name, budget);
  endtask

  // Monitor: every load strobe / song end must match the head of the queue
  always @(negedge clk) begin : monitor
    ev_t e;
    if (reset && (load_new_note || song_done)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: load=%0d done=%0d song=%0d note=%0d, nothing expected",
                 load_new_note, song_done, current_song, note_to_load);
      end else begin
        e = exp_q.pop_front();
        chk("sb_kind", 32'(song_done), 32'(e.is_done));
        chk("sb_song", 32'(current_song), 32'(e.song));
        if (!e.is_done) begin
          chk("sb_note", 32'(note_to_load), 32'(e.note));
          chk("sb_dur", 32'(duration_to_load), 32'(e.dur));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0] = w(10, 3);
    rom[1] = w(12, 0);
    for (int i = 0; i < 32; i++) rom[32 + i] = w((i == 5) ? 0 : i + 1, 1);
    rom[64] = w(7, 6);
    rom[65] = w(8, 5);
    rom[66] = w(9, 5);
    rom[67] = w(0, 5);
    rom[68] = w(11, 0);
    rom[96] = w(20, 4);
    rom[97] = w(21, 4);

    push_load(10, 3, 0);
    push_done(0);
    for (int i = 0; i < 32; i++) push_load((i == 5) ? 0 : i + 1, 1, 1);
    push_done(1);
    push_load(7, 6, 2);
    push_load(8, 5, 2);
    push_load(9, 5, 2);
    push_load(0, 5, 2);
    push_done(2);
    push_load(20, 4, 3);
    push_load(10, 3, 0);
    push_done(0);
    push_load(1, 1, 1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_load", 32'(load_new_note), 0);
    chk("rst_song_done", 32'(song_done), 0);
    chk("rst_play_en", 32'(play_enable), 0);
    chk("rst_song", 32'(current_song), 0);
    chk("rst_note_dur", 32'({note_to_load, duration_to_load}), 0);
    reset = 1'b1;

    // IDLE ignores next_song
    repeat (3) @(negedge clk);
    next_song = 1'b1;
    @(negedge clk);
    next_song = 1'b0;
    @(negedge clk);
    chk("idle_skip_song", 32'(current_song), 0);
    chk("idle_rom_addr", 32'(rom_addr), 0);
    chk("idle_play_en", 32'(play_enable), 0);

    // Song 0: first load exactly 3 cycles after play
    play = 1'b1;
    repeat (3) @(negedge clk);
    chk("first_load_latency", 32'(load_new_note), 1);
    wait_ev("song0_done", 1, 50);
    @(negedge clk);
    chk("s0_next_song", 32'(current_song), 1);
    chk("s0_next_addr", 32'(rom_addr), 32'h20);

    // Song 1: 32 words, wraps into song 2 with no 33rd fetch
    wait_ev("song1_done", 1, 400);
    @(negedge clk);
    chk("s1_next_song", 32'(current_song), 2);
    chk("s1_next_addr", 32'(rom_addr), 32'h40);

    // Pause in PLAYING with done high, then resume
    wait_ev("song2_load0", 0, 10);
    play = 1'b0;
    done_force = 1'b1;
    repeat (4) @(negedge clk);
    chk("pause_play_en", 32'(play_enable), 0);
    chk("pause_rom_addr", 32'(rom_addr), 32'h40);
    chk("pause_no_load", 32'(load_new_note), 0);
    play = 1'b1;
    @(negedge clk);
    chk("resume_rom_addr", 32'(rom_addr), 32'h41);

    // done held high: one load per word (scoreboard), then song 3
    wait_ev("song2_done", 1, 100);
    @(negedge clk);
    chk("s2_next_song", 32'(current_song), 3);
    chk("s2_next_addr", 32'(rom_addr), 32'h60);

    // next_song together with done in PLAYING
    wait_ev("song3_load0", 0, 10);
    @(negedge clk);
    @(negedge clk);
    next_song = 1'b1;
    @(negedge clk);
    next_song = 1'b0;
    chk("skip_song_wrap", 32'(current_song), 0);
    chk("skip_rom_addr", 32'(rom_addr), 0);
    chk("skip_no_done", 32'(song_done), 0);

    // Reset asserted mid-ARM acts without a clock edge
    wait_ev("skip_song0_done", 1, 50);
    wait_ev("song1_again_load", 0, 10);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_load", 32'(load_new_note), 0);
    chk("arst_play_en", 32'(play_enable), 0);
    chk("arst_song", 32'(current_song), 0);
    chk("arst_rom_addr", 32'(rom_addr), 0);
    chk("sb_drained_pre_reset", 32'(exp_q.size()), 0);
    @(negedge clk);
    push_load(10, 3, 0);
    done_force = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("restart_rom_addr", 32'(rom_addr), 0);
    chk("restart_play_en", 32'(play_enable), 1);
    wait_ev("restart_load", 0, 10);
    repeat (3) @(negedge clk);
    chk("sb_drained_end", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
